// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: registered EX/MEM result, HI/LO registers, iterative divider.
// Define EX_DIV_EN to build the 32-cycle divider; otherwise DIV/DIVU return 0.
module ex_alu_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [4:0]    alucontrol,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [4:0]    sa,
    input  logic          stall_in,
    input  logic          flush,
    output logic          in_ready,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] result,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_NOR  = 5'b00011;
    localparam logic [4:0] OP_LUI  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_SLLV = 5'b01011;
    localparam logic [4:0] OP_SRLV = 5'b01100;
    localparam logic [4:0] OP_SRAV = 5'b01101;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b11010;
    localparam logic [4:0] OP_MFLO = 5'b11011;
    localparam logic [4:0] OP_MTHI = 5'b11100;
    localparam logic [4:0] OP_MTLO = 5'b11101;
`ifdef EX_DIV_EN
    localparam logic [4:0] OP_DIV  = 5'b11000;
    localparam logic [4:0] OP_DIVU = 5'b11001;
`endif

    logic [DW-1:0] result_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          out_valid_q;
    logic [DW-1:0] alu_d;
    logic          accept;

    always_comb begin
        alu_d = '0;
        case (alucontrol)
            OP_NOP:  alu_d = '0;
            OP_OR:   alu_d = a | b;
            OP_XOR:  alu_d = a ^ b;
            OP_NOR:  alu_d = ~(a | b);
            OP_AND:  alu_d = a & b;
            OP_LUI:  alu_d = {b[15:0], 16'h0000};
            OP_SLL:  alu_d = b << sa;
            OP_SRL:  alu_d = b >> sa;
            OP_SRA:  alu_d = $signed(b) >>> sa;
            OP_SLLV: alu_d = b << a[4:0];
            OP_SRLV: alu_d = b >> a[4:0];
            OP_SRAV: alu_d = $signed(b) >>> a[4:0];
            OP_ADD:  alu_d = a + b;
            OP_MFHI: alu_d = hi_q;
            OP_MFLO: alu_d = lo_q;
            default: alu_d = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_e;

    state_e        state_q;
    logic [4:0]    cnt_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] dvs_q;
    logic [DW-1:0] dend_q;
    logic          qneg_q;
    logic          rneg_q;
    logic          dz_q;

    logic          is_div;
    logic          sgn;
    logic [DW-1:0] a_abs;
    logic [DW-1:0] b_abs;
    logic [DW:0]   shifted;
    logic          ge;
    logic [DW-1:0] rem_d;
    logic [DW-1:0] quo_d;
    logic [DW-1:0] q_fix;
    logic [DW-1:0] r_fix;

    assign is_div = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
    assign sgn    = (alucontrol == OP_DIV);
    assign a_abs  = (sgn && a[DW-1]) ? -a : a;
    assign b_abs  = (sgn && b[DW-1]) ? -b : b;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_d   = ge ? DW'(shifted - {1'b0, dvs_q}) : shifted[DW-1:0];
        quo_d   = {quo_q[DW-2:0], ge};
        q_fix   = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
        r_fix   = dz_q ? dend_q : (rneg_q ? -rem_q : rem_q);
    end

    assign busy = (state_q != S_IDLE);
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !busy && !stall_in;
    assign accept   = in_valid && in_ready;

`ifdef EX_DIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dend_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept && is_div) begin
                        quo_q       <= a_abs;
                        rem_q       <= '0;
                        dvs_q       <= b_abs;
                        dend_q      <= a;
                        qneg_q      <= sgn && (a[DW-1] ^ b[DW-1]);
                        rneg_q      <= sgn && a[DW-1];
                        dz_q        <= (b == '0);
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= S_DIV;
                    end else if (accept) begin
                        result_q    <= alu_d;
                        out_valid_q <= 1'b1;
                        if (alucontrol == OP_MTHI) hi_q <= a;
                        if (alucontrol == OP_MTLO) lo_q <= a;
                    end else if (!stall_in) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                    if (!stall_in) out_valid_q <= 1'b0;
                end
                S_DONE: begin
                    if (!stall_in) begin
                        hi_q        <= r_fix;
                        lo_q        <= q_fix;
                        result_q    <= q_fix;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            result_q    <= alu_d;
            out_valid_q <= 1'b1;
            if (alucontrol == OP_MTHI) hi_q <= a;
            if (alucontrol == OP_MTLO) lo_q <= a;
        end else if (!stall_in) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit against an arithmetic reference model.
// Divider checks are built when EX_DIV_EN is defined.
module tb_ex_alu_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic        stall_in;
    logic        flush;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_hi, m_lo, m_res;
    logic        m_ov;

    always #5 clk = ~clk;

    ex_alu_unit #(.DW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .alucontrol(alucontrol), .a(a), .b(b), .sa(sa),
        .stall_in(stall_in), .flush(flush),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
        .result(result), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] c,
            input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        longint unsigned xu = x;
        longint unsigned yu = y;
        longint          ys = $signed(y);
        longint          d;
        longint          p;
        longint unsigned m32 = 64'd1 << 32;
        int              sh;
        sh = (c == 5'b01011 || c == 5'b01100 || c == 5'b01101) ? int'(x[4:0]) : int'(s);
        d  = longint'(64'd1 << sh);
        case (c)
            5'b00001: return x | y;
            5'b00010: return x ^ y;
            5'b00011: return ~(x | y);
            5'b00111: return x & y;
            5'b00100: return 32'(((yu % 65536) * 65536) % m32);
            5'b01000, 5'b01011: return 32'((yu * longint'(d)) % m32);
            5'b01001, 5'b01100: return 32'(yu / d);
            5'b01010, 5'b01101: begin
                p = (ys >= 0) ? ys / d : -((-ys + d - 1) / d);
                return 32'(p);
            end
            5'b10000: return 32'((xu + yu) % m32);
            5'b11010: return m_hi;
            5'b11011: return m_lo;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic op(input logic [4:0] c, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] s, input string tag);
        alucontrol = c; a = x; b = y; sa = s; in_valid = 1'b1;
        m_res = ref_alu(c, x, y, s);
        m_ov  = 1'b1;
        if (c == 5'b11100) m_hi = x;
        if (c == 5'b11101) m_lo = x;
        tick;
        in_valid = 1'b0;
        check({tag, ".res"}, result, m_res);
        check({tag, ".ov"}, {31'b0, out_valid}, {31'b0, m_ov});
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_ov = 1'b0;
    endtask

`ifdef EX_DIV_EN
    task automatic div_ref(input logic sgn, input logic [31:0] x,
                           input logic [31:0] y, output logic [31:0] q,
                           output logic [31:0] r);
        longint xs = $signed(x);
        longint ys = $signed(y);
        longint qq, rr;
        if (y == 0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sgn) begin
            qq = xs / ys;
            rr = xs % ys;
            q = 32'(qq);
            r = 32'(rr);
        end else begin
            q = x / y;
            r = x % y;
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] x,
                           input logic [31:0] y, input int st, input string tag);
        logic [31:0] q, r;
        int nb;
        div_ref(sgn, x, y, q, r);
        alucontrol = sgn ? 5'b11000 : 5'b11001;
        a = x; b = y; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            stall_in = (nb >= 33) && (nb < 33 + st);
            tick;
        end
        stall_in = 1'b0;
        m_hi = r; m_lo = q; m_res = q; m_ov = 1'b1;
        check({tag, ".busy"}, 32'(nb), 32'(33 + st));
        check({tag, ".ov"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".res"}, result, q);
        check({tag, ".lo"}, lo, q);
        check({tag, ".hi"}, hi, r);
    endtask
`endif

    initial begin
        logic [4:0]  c;
        logic [31:0] x, y;
        logic [4:0]  s;
        logic        v, st;

        rst = 1'b0; in_valid = 1'b0; alucontrol = '0; a = '0; b = '0;
        sa = '0; stall_in = 1'b0; flush = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_ov = 1'b0;

        do_reset;
        check("rst.ov", {31'b0, out_valid}, 32'd0);
        check("rst.res", result, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.rdy", {31'b0, in_ready}, 32'd1);

        op(5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, "and");
        check("and.k", result, 32'hF000F000);
        op(5'b01010, 32'h0, 32'h80000000, 5'd4, "sra");
        check("sra.k", result, 32'hF8000000);
        op(5'b01100, 32'h24, 32'h80000000, 5'd0, "srlv");
        check("srlv.k", result, 32'h08000000);
        op(5'b10000, 32'hFFFFFFFF, 32'h2, 5'd0, "addwrap");
        check("add.k", result, 32'h1);
        op(5'b11100, 32'h11112222, 32'h0, 5'd0, "mthi");
        op(5'b11101, 32'h33334444, 32'h0, 5'd0, "mtlo");
        check("mthi.hi", hi, 32'h11112222);
        check("mtlo.lo", lo, 32'h33334444);
        op(5'b11010, 32'h0, 32'h0, 5'd0, "mfhi");
        op(5'b11111, 32'h5, 32'h7, 5'd0, "undef");

        tick;
        check("idle.ov", {31'b0, out_valid}, 32'd0);
        m_ov = 1'b0;

        for (int i = 0; i < 200; i++) begin
            do c = 5'($urandom_range(0, 31));
            while (c == 5'b11000 || c == 5'b11001);
            x  = $urandom;
            y  = $urandom;
            s  = 5'($urandom_range(0, 31));
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 5) == 0);
            alucontrol = c; a = x; b = y; sa = s;
            in_valid = v; stall_in = st;
            if (!st && v) begin
                m_res = ref_alu(c, x, y, s);
                m_ov = 1'b1;
                if (c == 5'b11100) m_hi = x;
                if (c == 5'b11101) m_lo = x;
            end else if (!st) begin
                m_ov = 1'b0;
            end
            tick;
            check("rnd.ov", {31'b0, out_valid}, {31'b0, m_ov});
            check("rnd.res", result, m_res);
            check("rnd.hi", hi, m_hi);
            check("rnd.lo", lo, m_lo);
        end
        in_valid = 1'b0; stall_in = 1'b0;

        op(5'b00001, 32'h0F0F0000, 32'h000000F0, 5'd0, "or");
        alucontrol = 5'b00001; a = 32'h1; b = 32'h2; in_valid = 1'b1; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        m_ov = 1'b0;
        check("flush1.ov", {31'b0, out_valid}, 32'd0);
        check("flush1.res", result, m_res);

`ifdef EX_DIV_EN
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");
        check("div.k.lo", lo, 32'hFFFFFFFD);
        check("div.k.hi", hi, 32'hFFFFFFFF);
        op(5'b11010, 32'h0, 32'h0, 5'd0, "mfhi_div");
        run_div(1'b0, 32'd7, 32'd0, 0, "divu_z");
        check("divu_z.k", lo, 32'hFFFFFFFF);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 3, "div_ovf");
        check("ovf.k.lo", lo, 32'h80000000);
        check("ovf.k.hi", hi, 32'h0);
        run_div(1'b1, 32'hFFFFFF00, 32'd0, 0, "div_z");
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i[0]) y = -y;
            run_div(i < 4, x, y, 0, "div_rnd");
        end

        alucontrol = 5'b11001; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        m_ov = 1'b0;
        check("flush.busy", {31'b0, busy}, 32'd0);
        check("flush.ov", {31'b0, out_valid}, 32'd0);
        check("flush.hi", hi, m_hi);
        check("flush.lo", lo, m_lo);
        op(5'b11010, 32'h0, 32'h0, 5'd0, "flush.mfhi");

        alucontrol = 5'b11000; a = 32'd99; b = 32'd5; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_ov = 1'b0;
        check("rstdiv.busy", {31'b0, busy}, 32'd0);
        check("rstdiv.ov", {31'b0, out_valid}, 32'd0);
        check("rstdiv.hi", hi, 32'd0);
        check("rstdiv.lo", lo, 32'd0);
        check("rstdiv.res", result, 32'd0);
`else
        op(5'b11000, 32'd7, 32'd2, 5'd0, "div_off");
        check("div_off.hi", hi, m_hi);
        check("div_off.lo", lo, m_lo);
        check("div_off.busy", {31'b0, busy}, 32'd0);
        op(5'b11001, 32'd7, 32'd0, 5'd0, "divu_off");
`endif

        op(5'b00100, 32'h0, 32'h0000ABCD, 5'd0, "lui_pre");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_ov = 1'b0;
        check("rstov.ov", {31'b0, out_valid}, 32'd0);
        check("rstov.res", result, 32'd0);
        check("rstov.hi", hi, 32'd0);
        op(5'b00100, 32'h0, 32'h00001234, 5'd0, "lui");
        check("lui.k", result, 32'h12340000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
